// File: rtl/noc_pkg.sv
// noc_pkg: router port codes and sizes shared by allocator, crossbar and input buffers
package noc_pkg;
  localparam int PORTS = 5;
  localparam int SEL_W = 3;
  typedef enum logic [2:0] {P_N = 3'd0, P_S = 3'd1, P_W = 3'd2, P_E = 3'd3, P_L = 3'd4} port_e;
endpackage

// File: rtl/rr_arbiter_5.sv
// rr_arbiter_5: 5-way round-robin arbiter, search starts one above ptr
// req: request vector; ptr: last granted index; gnt: one-hot grant (0 if no request)
module rr_arbiter_5 (
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [4:0] gnt
);
  logic [3:0] s;
  // Walk offsets from farthest to nearest so the nearest requester above ptr wins.
  always_comb begin
    gnt = '0;
    s = '0;
    for (int k = 5; k >= 1; k--) begin
      s = {1'b0, ptr} + 4'(k);
      s = (s >= 4'd5) ? s - 4'd5 : s;
      if (req[s[2:0]]) gnt = 5'b1 << s[2:0];
    end
  end
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: wormhole switch allocator with per-output packet locks
// clk_i/rst_n_i: clock, sync active-low reset
// req_i/dest_i/tail_i: per-input request, destination port code, tail marker
// out_ready_i: per-output downstream ready
// cs_sel_o/cs_enable_o: per-input crossbar select and enable
// grant_o: per-input flit transfer (buffer pop); uturn_err_o: sticky bad-destination flag
module switch_allocator #(
  parameter int PORTS = 5,
  parameter int SEL_W = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [PORTS-1:0]       req_i,
  input  logic [PORTS*SEL_W-1:0] dest_i,
  input  logic [PORTS-1:0]       tail_i,
  input  logic [PORTS-1:0]       out_ready_i,
  output logic [PORTS*SEL_W-1:0] cs_sel_o,
  output logic [PORTS-1:0]       cs_enable_o,
  output logic [PORTS-1:0]       grant_o,
  output logic [PORTS-1:0]       uturn_err_o
);
  import noc_pkg::*;
  logic [PORTS-1:0] locked;
  logic [SEL_W-1:0] owner [PORTS];
  logic [SEL_W-1:0] ptr [PORTS];
  logic [SEL_W-1:0] dest [PORTS];
  logic [SEL_W-1:0] gidx [PORTS];
  logic [PORTS-1:0] cand [PORTS];
  logic [PORTS-1:0] arb [PORTS];
  logic [PORTS-1:0] gnt [PORTS];
  logic [PORTS-1:0] owns, bad;
  // An input holding a lock elsewhere may not compete for a new output.
  always_comb begin
    owns = '0;
    for (int j = 0; j < PORTS; j++)
      if (locked[j]) owns[owner[j]] = 1'b1;
    for (int i = 0; i < PORTS; i++) begin
      dest[i] = dest_i[i*SEL_W +: SEL_W];
      bad[i] = req_i[i] && (32'(dest[i]) == i || 32'(dest[i]) >= PORTS);
    end
    for (int j = 0; j < PORTS; j++)
      for (int i = 0; i < PORTS; i++)
        cand[j][i] = req_i[i] && 32'(dest[i]) == j && i != j && !owns[i];
  end
  for (genvar j = 0; j < PORTS; j++) begin : g_arb
    rr_arbiter_5 u_arb (.req(cand[j]), .ptr(ptr[j]), .gnt(arb[j]));
  end
  // A locked output serves only its owner; an idle one takes the arbiter's pick.
  always_comb begin
    grant_o = '0;
    cs_sel_o = '0;
    for (int j = 0; j < PORTS; j++) begin
      gnt[j] = '0;
      gidx[j] = '0;
      if (rst_n_i && out_ready_i[j])
        gnt[j] = locked[j] ? ((req_i[owner[j]] && 32'(dest[owner[j]]) == j) ? PORTS'(1) << owner[j] : '0) : arb[j];
      for (int i = 0; i < PORTS; i++) begin
        if (gnt[j][i]) gidx[j] = SEL_W'(i);
        grant_o[i] = grant_o[i] | gnt[j][i];
      end
    end
    for (int i = 0; i < PORTS; i++)
      cs_sel_o[i*SEL_W +: SEL_W] = grant_o[i] ? dest[i] : '0;
    cs_enable_o = grant_o;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      locked <= '0;
      uturn_err_o <= '0;
      for (int j = 0; j < PORTS; j++) begin
        owner[j] <= '0;
        ptr[j] <= SEL_W'(P_L);
      end
    end else begin
      uturn_err_o <= uturn_err_o | bad;
      for (int j = 0; j < PORTS; j++)
        if (|gnt[j]) begin
          ptr[j] <= gidx[j];
          owner[j] <= gidx[j];
          locked[j] <= !tail_i[gidx[j]];
        end
    end
  end
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed checks of locking, round-robin, backpressure, u-turn and reset
module tb_switch_allocator;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] req, tail, rdy, cs_en, grant, uturn;
  logic [14:0] dest, cs_sel;
  int total = 0;
  int bad = 0;
  int order [9] = '{0, 0, 0, 1, 1, 1, 4, 4, 4};
  int rem [5];

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .dest_i(dest), .tail_i(tail),
    .out_ready_i(rdy), .cs_sel_o(cs_sel), .cs_enable_o(cs_en), .grant_o(grant),
    .uturn_err_o(uturn)
  );

  function automatic logic [14:0] dv(input logic [2:0] d0, d1, d2, d3, d4);
    return {d4, d3, d2, d1, d0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 5'b11111;
    dest = dv(3, 0, 3, 4, 2);
    tail = 5'b11111;
    rdy = 5'b11111;
    tick();
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_en", cs_en, 0);
    chk("rst_sel", cs_sel, 0);
    chk("rst_uturn", uturn, 0);
    // single flit N->E
    rst_n = 1'b1;
    req = 5'b00001;
    dest = dv(3, 0, 0, 0, 0);
    tail = 5'b00001;
    #1;
    chk("single_grant", grant, 5'b00001);
    chk("single_sel", cs_sel, 15'd3);
    chk("single_en", cs_en, 5'b00001);
    tick();
    req = 5'b00010;
    dest = dv(0, 3, 0, 0, 0);
    tail = 5'b00010;
    #1;
    chk("single_idle", grant, 5'b00010);
    tick();
    // contention on W: N, S, L each 3 flits
    rem = '{3, 3, 0, 0, 3};
    dest = dv(2, 2, 0, 0, 2);
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 5; i++) begin
        req[i] = rem[i] > 0;
        tail[i] = rem[i] == 1;
      end
      #1;
      chk($sformatf("cont%0d", k), grant, 5'b1 << order[k]);
      if (k == 0) chk("cont_sel", cs_sel, 15'd2);
      rem[order[k]]--;
      tick();
    end
    // backpressure: S locks L, N waits behind it
    req = 5'b00010;
    dest = dv(4, 4, 0, 0, 0);
    tail = 5'b00001;
    #1;
    chk("bp_head", grant, 5'b00010);
    tick();
    req = 5'b00011;
    rdy = 5'b01111;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_stall%0d", k), grant, 0);
      tick();
    end
    rdy = 5'b11111;
    req = 5'b00001;
    #1;
    chk("bp_owner_idle", grant, 0);
    tick();
    req = 5'b00011;
    #1;
    chk("bp_body1", grant, 5'b00010);
    chk("bp_sel", cs_sel, 15'h20);
    tick();
    #1;
    chk("bp_body2", grant, 5'b00010);
    tick();
    tail = 5'b00011;
    #1;
    chk("bp_tail", grant, 5'b00010);
    tick();
    req = 5'b00001;
    #1;
    chk("bp_next", grant, 5'b00001);
    tick();
    // u-turn and out-of-range destination
    req = 5'b00100;
    dest = dv(0, 0, 2, 0, 0);
    tail = 5'b00100;
    #1;
    chk("uturn_grant", grant, 0);
    chk("uturn_pre", uturn, 0);
    tick();
    req = 5'b01000;
    dest = dv(0, 0, 0, 7, 0);
    tail = 5'b01000;
    #1;
    chk("uturn_set", uturn, 5'b00100);
    chk("range_grant", grant, 0);
    tick();
    req = 5'b00000;
    #1;
    chk("uturn_sticky", uturn, 5'b01100);
    // reset mid-packet: N locks E
    req = 5'b00001;
    dest = dv(3, 0, 3, 0, 0);
    tail = 5'b00000;
    #1;
    chk("mid_head", grant, 5'b00001);
    tick();
    req = 5'b00100;
    tail = 5'b00100;
    #1;
    chk("mid_blocked", grant, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", grant, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_new", grant, 5'b00100);
    chk("mid_sel", cs_sel, 15'(3 << 6));
    chk("mid_uturn", uturn, 0);
    tick();
    // all five in parallel
    req = 5'b11111;
    dest = dv(1, 0, 3, 4, 2);
    tail = 5'b11111;
    #1;
    chk("par_grant", grant, 5'b11111);
    chk("par_sel", cs_sel, dv(1, 0, 3, 4, 2));
    chk("par_en", cs_en, 5'b11111);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
